// File: rtl/decoder2_to_4_seq.sv
// Registered 2-to-4 one-hot decoder with a programmable hold time and a symbol counter.
// Latency: a code accepted at edge k drives out from edge k to edge k+HOLD_CYCLES.
// Backpressure: in_ready is low while a hold is in progress, during reset and during flush.
module decoder2_to_4_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  output logic [3:0]       out,
  output logic             out_valid,
  output logic [CNT_W-1:0] sym_cnt
);

  // Reject illegal parameterisations at elaboration time.
  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("decoder2_to_4_seq: HOLD_CYCLES must be in 1..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("decoder2_to_4_seq: CNT_W must be at least 1");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // The hold counter reloads with HOLD_CYCLES-1 because the accepting edge
  // itself already counts as the first cycle of the hold.
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       out_d;
  logic             out_valid_d;
  logic [CNT_W-1:0] sym_cnt_d;
  logic             accept;

  // Ready depends only on state and the control inputs, never on in_valid.
  always_comb begin
    in_ready = rst_n && !flush && ((state_q == IDLE) || (hold_q == 8'd0));
    accept   = in_valid && in_ready;
  end

  // Next-state and next-output logic; flush outranks accept, accept outranks hold expiry.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out_d       = out;
    out_valid_d = out_valid;
    sym_cnt_d   = sym_cnt;
    if (flush) begin
      state_d     = IDLE;
      hold_d      = 8'd0;
      out_d       = 4'b0000;
      out_valid_d = 1'b0;
    end else if (accept) begin
      // Back-to-back accepts land here too, so out switches with no zero cycle.
      state_d     = HOLD;
      hold_d      = HOLD_RELOAD;
      out_d       = 4'b0001 << in_code;
      out_valid_d = 1'b1;
      sym_cnt_d   = sym_cnt + CNT_W'(1);
    end else if (state_q == HOLD) begin
      if (hold_q != 8'd0) begin
        hold_d = hold_q - 8'd1;
      end else begin
        state_d     = IDLE;
        out_d       = 4'b0000;
        out_valid_d = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= 8'd0;
      out       <= 4'b0000;
      out_valid <= 1'b0;
      sym_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      sym_cnt   <= sym_cnt_d;
    end
  end

endmodule

// File: doc/decoder2_to_4_seq.md
# decoder2_to_4_seq

Registered 2-to-4 one-hot decoder with a valid/ready input handshake and a programmable output hold time. It is the receive-side counterpart of the 4-to-2 encoder in the combinational-circuit library. It takes a stream of 2-bit codes, drives the matching one-hot line for `HOLD_CYCLES` clocks per code, and counts decoded symbols. It sits between a code source (FIFO, UART payload, encoder output) and one-hot consumers such as LED or select lines.

## Interface
- `HOLD_CYCLES`, default 4: clocks each decoded one-hot value stays asserted. Legal range is 1..255; elaboration must fail outside it.
- `CNT_W`, default 8: width of the symbol counter.

- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `flush` input 1: synchronous abort of the current hold.
- `in_valid` input 1: `in_code` is presented.
- `in_ready` output 1: block accepts a code on this edge. Combinational from state.
- `in_code` input 2: code to decode.
- `out` output 4: registered one-hot. Code 00→0001, 01→0010, 10→0100, 11→1000.
- `out_valid` output 1: registered; high while `out` is non-zero.
- `sym_cnt` output `CNT_W`: registered count of accepted codes. Wraps to 0 after all-ones.

## Operation
- Reset (`rst_n`=0 at an edge) sets:
  - state to IDLE
  - `out`=4'b0000, `out_valid`=0, `sym_cnt`=0, hold counter=0
- `in_ready` is forced to 0 while `rst_n`=0 or `flush`=1.
- States are IDLE and HOLD.
- `in_ready` = IDLE, or (HOLD and hold counter == 0).
- Accept = `in_valid` & `in_ready`. At an accepting edge:
  - `out` ← one-hot(`in_code`), `out_valid` ← 1
  - hold counter ← `HOLD_CYCLES`-1
  - state ← HOLD
  - `sym_cnt` ← `sym_cnt`+1, modulo 2^`CNT_W`
- HOLD with counter > 0: the counter decrements each edge and `out` is unchanged. `in_code` and `in_valid` are ignored.
- HOLD with counter == 0 and no accept: `out` ← 0, `out_valid` ← 0, state ← IDLE.
- HOLD with counter == 0 and accept (back-to-back): `out` switches directly to the new one-hot with no zero cycle, and HOLD restarts.
- `flush`=1 with `rst_n`=1: `out` ← 0, `out_valid` ← 0, state ← IDLE, hold counter ← 0.
  - `sym_cnt` is preserved.
  - No accept occurs, even if `in_valid`=1 (flush has priority).
- Reset has priority over `flush`.
- `HOLD_CYCLES`=1: the counter is always 0 in HOLD, so `in_ready` stays high and one code is decoded per clock.
- `out` is never multi-hot. `out_valid` equals the reduction-OR of `out` at all times.
- `in_code` values X/Z are not handled; the source guarantees known values whenever `in_valid`=1.

## Timing
- Latency: code accepted at edge k appears on `out` after edge k, visible in cycle k+1.
- Hold: `out` stays non-zero for exactly `HOLD_CYCLES` cycles, from edge k to edge k+`HOLD_CYCLES`.
- Without a new accept, `out` returns to 0 at edge k+`HOLD_CYCLES`. With a back-to-back accept at that edge, it takes the new value instead.
- Throughput: one code per `HOLD_CYCLES` clocks with `in_valid` held high.
- `in_ready` can rise in the same cycle the counter reaches 0. There is no combinational path from `in_valid` to `in_ready`.
- `sym_cnt` updates on the accepting edge, the same edge as `out`.
- Reset or `flush` asserted mid-hold clears `out` at that edge. The next accept is possible on the following edge, once `rst_n`=1 and `flush`=0.

## Test plan
- Reset: hold `rst_n`=0 for 3 clocks with `in_valid`=1 and `in_code`=2'b11.
  - Required: `out`=0000, `out_valid`=0, `sym_cnt`=0, `in_ready`=0 throughout.
  - After release: `in_ready`=1 in IDLE.
- Single decode, `HOLD_CYCLES`=4: pulse `in_code`=2'b10 for one accept.
  - Required: `out`=0100 for exactly 4 cycles, then 0000. `in_ready` low for cycles 1-3 and high in cycle 4. `sym_cnt`=1.
- Back-to-back all codes, `HOLD_CYCLES`=4: `in_valid` held high with 00, 01, 10, 11 presented each time `in_ready` is high.
  - Required: `out` goes 0001, 0010, 0100, 1000, each for 4 cycles with no 0000 gap. `sym_cnt`=4.
- `HOLD_CYCLES`=1 streaming: 8 consecutive codes 00, 01, 10, 11, 00, 01, 10, 11.
  - Required: one new one-hot per clock, each 1 cycle after its accept, and `in_ready` constantly 1.
- Flush mid-hold: accept 2'b01, then assert `flush` in hold cycle 2 with `in_valid`=1 and `in_code`=2'b11.
  - Required: `out`=0000 after that edge, no accept, `sym_cnt` unchanged at 1.
  - With `flush`=0 and `in_valid` kept at 1, the next edge accepts and gives `out`=1000.
- Counter wrap, `CNT_W`=8, `HOLD_CYCLES`=1: issue 256 accepts.
  - Required: `sym_cnt` reads 255 after the 255th and 0 after the 256th.
  - Reset after 10 further accepts returns `sym_cnt` to 0.
